sigdel_top: RTL and testbench

SIGDEL_TOP -- requirements
Module: sigdel_top

---
 rtl/sigdel_pkg.sv | 22 ++
 rtl/sigdel_cic.sv | 34 +++
 rtl/sigdel_top.sv | 112 +++++++++++
 tb/tb_sigdel_top.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sigdel_pkg.sv
// Shared constants, filter-order encoding and saturation helper for the sigma-delta decimator.
package sigdel_pkg;

  localparam int OSR       = 16;
  localparam int OSR_W     = $clog2(OSR);
  localparam int ACC_W     = 16;
  localparam int SINC1_SHL = 4;
  localparam int SINC3_SHR = 4;

  typedef enum logic [1:0] {
    ORD_SINC1  = 2'd0,
    ORD_SINC2  = 2'd1,
    ORD_SINC3  = 2'd2,
    ORD_SINC3B = 2'd3
  } order_e;

  // Clamp a widened filter result to the 8-bit output range.
  function automatic logic [7:0] sat8(input logic [ACC_W+3:0] v);
    return (|v[ACC_W+3:8]) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sigdel_cic.sv
// One CIC integrator/comb pair; integrator and comb outputs are the combinational
// "next" values so a chain of pairs settles within the sample or decimation cycle.
module sigdel_cic
  import sigdel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             int_en,
  input  logic             comb_en,
  input  logic [ACC_W-1:0] int_in,
  input  logic [ACC_W-1:0] comb_in,
  output logic [ACC_W-1:0] int_out,
  output logic [ACC_W-1:0] comb_out
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] dly_r;

  assign int_out  = acc_r + int_in;
  assign comb_out = comb_in - dly_r;

  // integrator accumulates at fs, comb delay captures at decimation
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_r <= {ACC_W{1'b0}};
      dly_r <= {ACC_W{1'b0}};
    end else begin
      if (int_en) acc_r <= int_out;
      if (comb_en) dly_r <= comb_in;
    end
  end

endmodule

// File: rtl/sigdel_top.sv
// Sigma-delta decimator: rate divider, sinc1..3 CIC (OSR 16), 8-bit scaling and PWM output.
// The PWM renderer is built only when SIGDEL_PWM_EN is defined; otherwise pwm_out is tied to 0.
module sigdel_top
  import sigdel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inp,
  output logic [7:0] out,
  output logic       pwm_out
);

  logic [7:0]       cnt_r;
  logic [5:0]       en_s;
  logic [3:0]       cfg_r;
  logic [OSR_W-1:0] fcnt_r;
  logic             flush_s;
  logic             fs_s;
  logic             fs_en_s;
  logic             dec_s;
  order_e           order_s;
  logic [ACC_W-1:0] x_s;
  logic [ACC_W-1:0] i1_s, i2_s, i3_s;
  logic [ACC_W-1:0] c1_s, c2_s, c3_s;
  logic [ACC_W-1:0] head_s;
  logic [ACC_W+3:0] wide_s;
  logic [7:0]       out_r;
  logic             unused_s;

  assign unused_s = ^{inp[7:5], cnt_r[7]};

  for (genvar k = 0; k < 6; k++) begin : g_en
    assign en_s[k] = &cnt_r[k+1:0];
  end

  assign order_s = order_e'(inp[4:3]);
  assign flush_s = (inp[4:1] != cfg_r);
  assign fs_s    = en_s[inp[2:1]];
  assign fs_en_s = fs_s & ~flush_s;
  assign dec_s   = fs_en_s & (fcnt_r == OSR_W'(OSR - 1));
  assign x_s     = {{(ACC_W-1){1'b0}}, inp[0]};

  // divider, configuration tracking and fs-pulse counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 8'd0;
      cfg_r  <= inp[4:1];
      fcnt_r <= {OSR_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + 8'd1;
      cfg_r <= inp[4:1];
      if (flush_s) fcnt_r <= {OSR_W{1'b0}};
      else if (fs_en_s) fcnt_r <= fcnt_r + OSR_W'(1);
    end
  end

  // comb chain starts at the integrator depth that matches the selected order
  always_comb begin
    head_s = i3_s;
    case (order_s)
      ORD_SINC1: head_s = i1_s;
      ORD_SINC2: head_s = i2_s;
      default:   head_s = i3_s;
    endcase
  end

  sigdel_cic u_stage1 (.clk(clk), .rst(rst), .clr(flush_s), .int_en(fs_en_s), .comb_en(dec_s),
                       .int_in(x_s), .comb_in(head_s), .int_out(i1_s), .comb_out(c1_s));
  sigdel_cic u_stage2 (.clk(clk), .rst(rst), .clr(flush_s), .int_en(fs_en_s), .comb_en(dec_s),
                       .int_in(i1_s), .comb_in(c1_s), .int_out(i2_s), .comb_out(c2_s));
  sigdel_cic u_stage3 (.clk(clk), .rst(rst), .clr(flush_s), .int_en(fs_en_s), .comb_en(dec_s),
                       .int_in(i2_s), .comb_in(c2_s), .int_out(i3_s), .comb_out(c3_s));

  // per-order scaling to the 8-bit range before saturation
  always_comb begin
    wide_s = {(ACC_W+4){1'b0}};
    case (order_s)
      ORD_SINC1: wide_s = {4'b0000, c1_s} << SINC1_SHL;
      ORD_SINC2: wide_s = {4'b0000, c2_s};
      default:   wide_s = {4'b0000, c3_s >> SINC3_SHR};
    endcase
  end

  // output register loads only on decimation
  always_ff @(posedge clk) begin
    if (rst) out_r <= 8'd0;
    else if (dec_s) out_r <= sat8(wide_s);
  end

  assign out = out_r;

`ifdef SIGDEL_PWM_EN
  logic [15:0] pc_r;
  logic        pwm_r;

  // free-running PWM counter and registered comparator
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= 16'd0;
      pwm_r <= 1'b0;
    end else begin
      pc_r  <= pc_r + 16'd1;
      pwm_r <= (pc_r[15:6] < {out_r, 2'b00});
    end
  end

  assign pwm_out = pwm_r;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_sigdel_top.sv
// Self-checking bench for sigdel_top: directed phases with a boxcar-convolution reference model.
module tb_sigdel_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inp = 8'd0;
  logic [7:0] out;
  logic       pwm_out;

  sigdel_top dut (.clk(clk), .rst(rst), .inp(inp), .out(out), .pwm_out(pwm_out));

  always #5 clk = ~clk;

`ifdef SIGDEL_PWM_EN
  localparam int PWM_HIGH_EXP = 16384;
`else
  localparam int PWM_HIGH_EXP = 0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int unsigned cnt_m = 0;
  int unsigned pc_m  = 0;
  logic [7:0]  out_m = 8'd0;
  logic        pwm_m = 1'b0;
  logic [3:0]  cfg_prev = 4'd0;
  int          q[$];
  int          nsamp = 0;
  int          pidx = 0;
  int          pat = 0;
  int          tick_no = 0;
  int          pwm_high = 0;
  int          t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int xs(input int i);
    return (i < q.size()) ? q[i] : 0;
  endfunction

  // sinc^N output = input convolved with N length-16 boxcars, taken at the newest sample
  function automatic int model_sum(input int order);
    int s = 0;
    if (order == 0) begin
      for (int a = 0; a < 16; a++) s += xs(a);
    end else if (order == 1) begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) s += xs(a + b);
    end else begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int c = 0; c < 16; c++) s += xs(a + b + c);
    end
    return s;
  endfunction

  function automatic int expect_out(input int order);
    int s = model_sum(order);
    int v = (order == 0) ? s * 16 : (order == 1) ? s : s / 16;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic set_cfg(input logic [1:0] order, input logic [1:0] rate);
    inp[4:3] = order;
    inp[2:1] = rate;
  endtask

  task automatic tick();
    int rate, order, mask;
    bit fs, b, flush, dec;
    logic [7:0] out_n;
    logic pwm_n;
    rate  = int'(inp[2:1]);
    order = int'(inp[4:3]);
    mask  = (1 << (rate + 2)) - 1;
    fs    = ((cnt_m & mask) == mask);
    case (pat)
      0:       b = 1'b0;
      1:       b = 1'b1;
      2:       b = (pidx % 2 == 0);
      3:       b = (pidx % 3 == 0);
      4:       b = (pidx % 4 == 0);
      default: b = 1'($urandom_range(0, 1));
    endcase
    if (!fs) b = 1'($urandom_range(0, 1));
    inp[0]   = b;
    inp[7:5] = 3'($urandom_range(0, 7));
    flush = (inp[4:1] != cfg_prev);
    out_n = out_m;
    dec   = 1'b0;
`ifdef SIGDEL_PWM_EN
    pwm_n = ((pc_m >> 6) < (int'(out_m) * 4));
`else
    pwm_n = 1'b0;
`endif
    if (flush) begin
      q.delete();
      nsamp = 0;
    end else if (fs) begin
      q.push_front(int'(b));
      if (q.size() > 48) void'(q.pop_back());
      nsamp++;
      pidx++;
      if (nsamp % 16 == 0) begin
        dec   = 1'b1;
        out_n = 8'(expect_out(order));
      end
    end
    @(posedge clk);
    #1;
    cnt_m    = (cnt_m + 1) % 256;
    pc_m     = (pc_m + 1) % 65536;
    out_m    = out_n;
    pwm_m    = pwm_n;
    cfg_prev = inp[4:1];
    tick_no++;
    if (pwm_out === 1'b1) pwm_high++;
    if (dec) check("out_dec", out, out_m);
    if (tick_no % 128 == 0) begin
      check("out_hold", out, out_m);
      check("pwm_model", pwm_out, pwm_m);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    cnt_m    = 0;
    pc_m     = 0;
    out_m    = 8'd0;
    pwm_m    = 1'b0;
    cfg_prev = inp[4:1];
    q.delete();
    nsamp    = 0;
  endtask

  initial begin
    do_reset(3);
    check("reset_out", out, 16'd0);
    check("reset_pwm", pwm_out, 16'd0);

    // all-zero bitstream in every order
    pat = 0;
    for (int o = 0; o < 3; o++) begin
      set_cfg(2'(o), 2'd0);
      run(5 * 64);
      check("zero_out", out, 16'd0);
      check("zero_pwm", pwm_out, 16'd0);
    end

    // all-ones sinc1 saturates
    pat = 1;
    set_cfg(2'd0, 2'd0);
    run(72);
    check("ones_sinc1", out, 16'd255);

    // alternating samples
    pat = 2;
    run(3 * 64);
    check("alt_sinc1", out, 16'd128);
    set_cfg(2'd2, 2'd0);
    run(3 * 64 + 8);
    check("alt_sinc3_p3", out, 16'd128);
    run(64);
    check("alt_sinc3_p4", out, 16'd128);

    // one sample in three
    pat = 3;
    set_cfg(2'd0, 2'd0);
    run(2 * 64 + 8);
    check("third_sinc1", 16'(out === 8'd80 || out === 8'd96), 16'd1);
    run(64);
    check("third_sinc1_b", 16'(out === 8'd80 || out === 8'd96), 16'd1);
    set_cfg(2'd1, 2'd0);
    run(3 * 64 + 8);
    check("third_sinc2", 16'(out >= 8'd69 && out <= 8'd101), 16'd1);

    // rate sweep: first decimation after flush gives 136, the next 255
    pat = 1;
    set_cfg(2'd0, 2'd0);
    run(80);
    check("sweep_pre", out, 16'd255);
    for (int r = 0; r < 4; r++) begin
      set_cfg(2'd1, 2'(r));
      t = 0;
      while (out !== 8'd136 && t < 2000) begin tick(); t++; end
      check("sweep_flush", out, 16'd136);
      t = 0;
      while (out !== 8'd255 && t < 2000) begin tick(); t++; end
      check("sweep_period", 16'(t), 16'(64 << r));
    end

    // random bitstreams in random modes
    pat = 5;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] o, r;
      o = 2'($urandom_range(0, 3));
      r = 2'($urandom_range(0, 1));
      set_cfg(o, r);
      run(5 * (64 << r));
      check("rand_out", out, out_m);
    end

    // reset mid-stream
    pat = 1;
    set_cfg(2'd0, 2'd0);
    run(80);
    check("pre_rst_out", out, 16'd255);
    do_reset(1);
    check("mid_rst_out", out, 16'd0);
    check("mid_rst_pwm", pwm_out, 16'd0);

    // quarter-density sinc1 holds out at 64; measure one full PWM period
    pat = 4;
    run(200);
    check("quarter_out", out, 16'd64);
    pwm_high = 0;
    run(65536);
    check("pwm_duty", 16'(pwm_high), 16'(PWM_HIGH_EXP));
    check("quarter_out_end", out, 16'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
